// File: rtl/conc_stim_sequencer.sv
// rtl/conc_stim_sequencer.sv - stimulus sequencer with entry memory, loop/one-shot playback and MISR response compaction
module conc_stim_sequencer #(
    parameter int                DATA_W   = 128,
    parameter int                RESP_W   = 128,
    parameter int                DEPTH    = 16,
    parameter int                ADDR_W   = $clog2(DEPTH),
    parameter int                RESP_LAT = 1,
    parameter logic [RESP_W-1:0] POLY     = {RESP_W{1'b0}} | 'h87
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W:0]   load_data,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic [ADDR_W-1:0] last_idx,
    input  logic [RESP_W-1:0] dut_resp,
    output logic [DATA_W-1:0] stim_data,
    output logic              stim_obs,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done,
    output logic              load_err,
    output logic [RESP_W-1:0] signature,
    output logic [15:0]       obs_count
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    // DRAIN lasts RESP_LAT cycles; the counter holds cycles remaining minus one
    localparam logic [1:0] DRAIN_INIT = (RESP_LAT > 0) ? 2'(RESP_LAT - 1) : 2'd0;

    state_t            state;
    logic [DATA_W:0]   mem [DEPTH];
    logic              loop_q;
    logic [ADDR_W-1:0] last_q;
    logic [1:0]        drain_cnt;
    logic [ADDR_W-1:0] pc_inc;
    logic              at_last;
    logic              start_ok;
    logic              flush;
    logic              obs_tap;
    logic [RESP_W-1:0] sig_next;

    assign pc_inc   = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign at_last  = (pc == last_q);
    assign start_ok = (state == IDLE) && start && !stop;
    assign flush    = stop && busy;
    assign sig_next = {signature[RESP_W-2:0], 1'b0}
                    ^ (signature[RESP_W-1] ? POLY : {RESP_W{1'b0}})
                    ^ dut_resp;

    // Entry memory: written only while idle, never reset so contents survive rst
    always_ff @(posedge clk) begin
        if (load_en && !busy) begin
            mem[load_addr] <= load_data;
        end
    end

    // Observe-flag delay line aligning each observe with its DUT response
    generate
        if (RESP_LAT == 0) begin : g_nopipe
            assign obs_tap = stim_obs;
        end else begin : g_pipe
            logic [RESP_LAT-1:0] pipe;
            assign obs_tap = pipe[RESP_LAT-1];
            // Shift stim_obs through; a stop empties the pipe so nothing stale is compacted
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pipe <= '0;
                end else if (flush) begin
                    pipe <= '0;
                end else begin
                    pipe <= (pipe << 1) | RESP_LAT'(stim_obs);
                end
            end
        end
    endgenerate

    // Playback FSM with registered stimulus and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            stim_data <= '0;
            stim_obs  <= 1'b0;
            pc        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            load_err  <= 1'b0;
            loop_q    <= 1'b0;
            last_q    <= '0;
            drain_cnt <= 2'd0;
        end else begin
            done     <= 1'b0;
            load_err <= load_en && busy;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        loop_q                <= loop;
                        last_q                <= last_idx;
                        pc                    <= '0;
                        {stim_obs, stim_data} <= mem[0];
                        busy                  <= 1'b1;
                        state                 <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        stim_data <= '0;
                        stim_obs  <= 1'b0;
                        pc        <= '0;
                    end else if (at_last && loop_q) begin
                        pc                    <= '0;
                        {stim_obs, stim_data} <= mem[0];
                    end else if (at_last) begin
                        stim_data <= '0;
                        stim_obs  <= 1'b0;
                        pc        <= '0;
                        if (RESP_LAT == 0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state     <= DRAIN;
                            drain_cnt <= DRAIN_INIT;
                        end
                    end else begin
                        pc                    <= pc_inc;
                        {stim_obs, stim_data} <= mem[pc_inc];
                    end
                end
                DRAIN: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (drain_cnt == 2'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 2'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // MISR compaction of responses whose delayed observe flag is set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            signature <= '0;
            obs_count <= '0;
        end else if (start_ok) begin
            signature <= '0;
            obs_count <= '0;
        end else if (obs_tap && !flush) begin
            signature <= sig_next;
            if (obs_count != 16'hFFFF) begin
                obs_count <= obs_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_conc_stim_sequencer.sv
// tb/tb_conc_stim_sequencer.sv - directed self-checking bench for conc_stim_sequencer
module tb_conc_stim_sequencer;

    localparam int DW  = 16;
    localparam int RW  = 16;
    localparam int DEP = 8;
    localparam int AW  = 3;
    localparam int LAT = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [DW:0]   load_data;
    logic          start;
    logic          stop;
    logic          loop;
    logic [AW-1:0] last_idx;
    logic [RW-1:0] dut_resp;
    logic [DW-1:0] stim_data;
    logic          stim_obs;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
    logic          load_err;
    logic [RW-1:0] signature;
    logic [15:0]   obs_count;

    int n_cmp = 0;
    int n_err = 0;

    conc_stim_sequencer #(
        .DATA_W(DW), .RESP_W(RW), .DEPTH(DEP), .ADDR_W(AW),
        .RESP_LAT(LAT), .POLY(16'h0087)
    ) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .stop(stop), .loop(loop),
        .last_idx(last_idx), .dut_resp(dut_resp), .stim_data(stim_data),
        .stim_obs(stim_obs), .pc(pc), .busy(busy), .done(done),
        .load_err(load_err), .signature(signature), .obs_count(obs_count)
    );

    always #5 clk = ~clk;

    // Modelled DUT: a one-cycle register of the stimulus word
    always @(posedge clk) dut_resp <= stim_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load(input int addr, input logic obs, input logic [DW-1:0] data);
        load_en   = 1'b1;
        load_addr = AW'(addr);
        load_data = {obs, data};
        tick();
        load_en   = 1'b0;
    endtask

    task automatic go(input logic lp, input int last);
        start    = 1'b1;
        loop     = lp;
        last_idx = AW'(last);
        tick();
        start    = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_stim"}, 32'(stim_data), 32'd0);
        chk({tag, "_obs"},  32'(stim_obs), 32'd0);
        chk({tag, "_pc"},   32'(pc), 32'd0);
    endtask

    initial begin
        rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; stop = 1'b0; loop = 1'b0; last_idx = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk_idle("reset");
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_lerr", 32'(load_err), 32'd0);
        chk("reset_sig", 32'(signature), 32'd0);
        chk("reset_cnt", 32'(obs_count), 32'd0);

        // One-shot of 1,2,3,4 with all observes
        for (int i = 0; i < 4; i++) load(i, 1'b1, DW'(i + 1));
        go(1'b0, 3);
        for (int i = 0; i < 4; i++) begin
            chk("os_stim", 32'(stim_data), 32'(i + 1));
            chk("os_pc", 32'(pc), 32'(i));
            chk("os_busy", 32'(busy), 32'd1);
            chk("os_done", 32'(done), 32'd0);
            tick();
        end
        chk("os_drain_busy", 32'(busy), 32'd1);
        chk("os_drain_stim", 32'(stim_data), 32'd0);
        chk("os_drain_done", 32'(done), 32'd0);
        tick();
        chk("os_end_busy", 32'(busy), 32'd0);
        chk("os_end_done", 32'(done), 32'd1);
        chk("os_cnt", 32'(obs_count), 32'd4);
        chk("os_sig", 32'(signature), 32'h0002);
        tick();
        chk("os_done_pulse", 32'(done), 32'd0);

        // Loop mode over entries 0..2, then stop
        go(1'b1, 2);
        for (int i = 0; i < 8; i++) begin
            chk("lp_stim", 32'(stim_data), 32'((i % 3) + 1));
            chk("lp_done", 32'(done), 32'd0);
            if (i == 7) stop = 1'b1;
            tick();
        end
        stop = 1'b0;
        chk_idle("lp_stop");
        chk("lp_stop_done", 32'(done), 32'd0);
        tick();
        chk("lp_after_done", 32'(done), 32'd0);

        // Only entry 2 observed
        for (int i = 0; i < 4; i++) load(i, (i == 2), DW'(16'h0010 + i));
        go(1'b0, 3);
        repeat (4) tick();
        chk("o2_drain_busy", 32'(busy), 32'd1);
        tick();
        chk("o2_done", 32'(done), 32'd1);
        chk("o2_cnt", 32'(obs_count), 32'd1);
        chk("o2_sig", 32'(signature), 32'h0012);

        // load_en during RUN is dropped and flagged
        go(1'b0, 3);
        load_en = 1'b1; load_addr = '0; load_data = {1'b1, 16'h00FF};
        tick();
        load_en = 1'b0;
        chk("le_err", 32'(load_err), 32'd1);
        tick();
        chk("le_err_pulse", 32'(load_err), 32'd0);
        repeat (3) tick();
        chk("le_done", 32'(done), 32'd1);
        go(1'b0, 0);
        chk("le_entry0", 32'(stim_data), 32'h0010);
        chk("le_entry0_obs", 32'(stim_obs), 32'd0);
        tick(); tick();
        chk("le_done2", 32'(done), 32'd1);

        // MISR feedback: responses 0x8000 then 0x0001
        load(0, 1'b1, 16'h8000);
        load(1, 1'b1, 16'h0001);
        go(1'b0, 1);
        repeat (3) tick();
        chk("fb_done", 32'(done), 32'd1);
        chk("fb_cnt", 32'(obs_count), 32'd2);
        chk("fb_sig", 32'(signature), 32'h0086);

        // Asynchronous reset mid-run at pc=2
        go(1'b1, 3);
        tick(); tick();
        chk("rs_pc2", 32'(pc), 32'd2);
        #1 rst = 1'b1;
        #1;
        chk_idle("rs_async");
        chk("rs_sig", 32'(signature), 32'd0);
        chk("rs_cnt", 32'(obs_count), 32'd0);
        chk("rs_done", 32'(done), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("rs_after_done", 32'(done), 32'd0);
        go(1'b0, 1);
        chk("rs_replay0", 32'(stim_data), 32'h8000);
        chk("rs_replay0_obs", 32'(stim_obs), 32'd1);
        tick();
        chk("rs_replay1", 32'(stim_data), 32'h0001);
        tick(); tick();
        chk("rs_replay_done", 32'(done), 32'd1);

        // start and stop together while idle
        start = 1'b1; stop = 1'b1; loop = 1'b0; last_idx = AW'(3);
        tick();
        start = 1'b0; stop = 1'b0;
        chk("ss_busy", 32'(busy), 32'd0);
        chk("ss_stim", 32'(stim_data), 32'd0);
        tick();
        chk("ss_busy2", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conc_stim_sequencer.md
# conc_stim_sequencer

Synthesizable, parametrised stimulus sequencer that replaces the behavioural program-counter/opcode-RAM stimulus loop used around DUT tops. It stores up to DEPTH stimulus entries, each an observe flag plus a DATA_W-bit input word. It plays them to the DUT one per clock in one-shot or loop mode. On observe cycles it compacts the DUT response into a MISR signature, with a configurable response latency.

## Interface
Parameters:
- DATA_W, 128, width of the stimulus word driven to the DUT (e.g. key).
- RESP_W, 128, width of the DUT response (e.g. out); must be ≥ 2.
- DEPTH, 16, number of stimulus entries; power of two, ≥ 2.
- ADDR_W, $clog2(DEPTH), entry index width.
- RESP_LAT, 1, cycles from stim_obs asserted to the matching dut_resp being valid; range 0..3.
- POLY, {RESP_W{1'b0}} | 'h87, MISR feedback polynomial.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_en  in  1  write one entry this cycle.
- load_addr  in  ADDR_W  entry index to write.
- load_data  in  DATA_W+1  bit DATA_W = observe flag; [DATA_W-1:0] = stimulus word.
- start  in  1  begin playback from entry 0 (single-cycle pulse).
- stop  in  1  abort playback.
- loop  in  1  sampled at start; 1 = wrap after last_idx, 0 = one-shot.
- last_idx  in  ADDR_W  sampled at start; index of final entry played.
- dut_resp  in  RESP_W  DUT response word.
- stim_data  out  DATA_W  registered stimulus word to DUT.
- stim_obs  out  1  registered observe flag to DUT (__obs).
- pc  out  ADDR_W  index of entry currently on stim_data.
- busy  out  1  playback active.
- done  out  1  one-cycle pulse when one-shot playback completes.
- load_err  out  1  one-cycle pulse when load_en arrives while busy.
- signature  out  RESP_W  MISR state.
- obs_count  out  16  number of responses compacted, saturating at 16'hFFFF.

## Operation
- Reset values: stim_data=0, stim_obs=0, pc=0, busy=0, done=0, load_err=0, signature=0, obs_count=0, and the latency pipe is cleared. The entry memory is not reset. Its contents are retained across rst.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - load_en writes mem[load_addr].
  - On start (with stop=0), latch loop and last_idx, clear signature and obs_count, and go to RUN.
  - start and stop together in IDLE: stop wins, and the sequencer stays in IDLE.
- RUN:
  - Each cycle drive mem[pc] onto stim_data/stim_obs, then advance pc.
  - At pc==last_idx:
    - loop=1: next pc is 0.
    - loop=0: go to DRAIN.
  - start is ignored.
  - load_en is dropped, and load_err pulses.
- DRAIN:
  - stim_data and stim_obs are driven to 0, and busy stays 1.
  - The sequencer waits RESP_LAT cycles so in-flight observes get compacted, then pulses done and returns to IDLE.
  - With RESP_LAT=0, DRAIN lasts 0 cycles: done pulses on the first idle cycle.
- stop (RUN or DRAIN): next cycle go to IDLE with busy=0, stim_data=0, stim_obs=0, and pc=0.
  - The latency pipe is flushed, so no further compaction occurs.
  - No done pulse.
  - signature and obs_count hold their values.
- Compaction:
  - A RESP_LAT-deep shift pipe carries stim_obs.
  - When the pipe output is 1, update the signature:
    - sig_next = ({sig[RESP_W-2:0],1'b0} ^ (sig[RESP_W-1] ? POLY : 0)) ^ dut_resp.
  - obs_count increments on each such update, saturating at 16'hFFFF.
  - With RESP_LAT=0, compaction uses stim_obs directly.

## Timing
- Assume start is high at edge t in IDLE:
  - From edge t: busy=1, pc=0, and stim_data/stim_obs = entry 0.
  - At edge t+k: entry k is on stim_data/stim_obs.
- One-shot with L = last_idx+1 entries:
  - Entries occupy L cycles.
  - busy stays high for L+RESP_LAT cycles.
  - done is high for exactly one cycle, the one immediately after busy falls.
- Loop mode: after entry last_idx, entry 0 follows in the next cycle, with no bubble.
- last_idx=0 with loop=1 replays entry 0 every cycle.
- The response to an observe driven at edge e is sampled at edge e+RESP_LAT.
- Memory write latency is 1 cycle: an entry written at edge w is playable by a start at edge w+1.
- A start in the same cycle that done pulses is accepted, because the sequencer is already in IDLE.
- An asynchronous rst mid-run returns all outputs to their reset values immediately; no done pulse.

## Test plan
- Load entries 0..3 = {obs=1, data=i+1}; start with loop=0, last_idx=3, RESP_LAT=1; dut_resp = registered stim_data. Required:
  - stim_data sequence 1,2,3,4.
  - busy for 5 cycles, then one done pulse.
  - obs_count=4.
  - signature equal to the reference MISR of responses 1,2,3,4.
- Loop mode, last_idx=2, with 8 cycles observed before stop. Required:
  - stim_data = 0x…1, 2, 3, 1, 2, 3, 1, 2.
  - No done pulse.
  - busy=0 and stim_data=0 one cycle after stop.
- Entries with obs=0 except entry 2; one-shot, last_idx=3. Required: obs_count=1, and signature = dut_resp value sampled at edge (t+2+RESP_LAT).
- load_en during RUN targeting entry 0 with data 0xFF. Required:
  - load_err pulses once.
  - The next run still plays the original entry 0.
- Assert rst during RUN at pc=2. Required:
  - All outputs are 0 immediately.
  - A subsequent start replays from entry 0 with the memory intact.
- start and stop together in IDLE. Required: busy remains 0, and stim_data remains 0.
